// File: rtl/dump_ctrl.sv
// dump_ctrl: walks the capture RAMs from the oldest sample and hands each
// byte of one channel to the host UART through a send/sent handshake.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for dump_req; rejects bad requests with dump_err
// READ      | raddr presented, RAM read data settling
// LOAD      | capture RAM byte into resp and pulse send_resp
// WAIT_SENT | hold raddr/resp until the UART reports resp_sent
// DONE      | pulse dump_done, drop dump_busy
module dump_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump_req,
  input  logic [2:0]      dump_ch,
  input  logic            capture_done,
  input  logic [LOG2-1:0] start_addr,
  input  logic [7:0]      rdataCH1,
  input  logic [7:0]      rdataCH2,
  input  logic [7:0]      rdataCH3,
  input  logic [7:0]      rdataCH4,
  input  logic [7:0]      rdataCH5,
  input  logic            resp_sent,
  output logic [LOG2-1:0] raddr,
  output logic [7:0]      resp,
  output logic            send_resp,
  output logic            dump_busy,
  output logic            dump_done,
  output logic            dump_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    LOAD      = 3'd2,
    WAIT_SENT = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Wrap point of the circular buffer; ENTRIES need not be a power of two.
  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  state_t          state;
  logic [LOG2-1:0] count;
  logic [2:0]      ch;
  logic [7:0]      rdata_sel;
  logic            ch_ok;

  assign ch_ok = (dump_ch >= 3'd1) && (dump_ch <= 3'd5);

  // Read-data mux for the channel latched at request acceptance.
  always_comb begin
    rdata_sel = 8'h00;
    case (ch)
      3'd1:    rdata_sel = rdataCH1;
      3'd2:    rdata_sel = rdataCH2;
      3'd3:    rdata_sel = rdataCH3;
      3'd4:    rdata_sel = rdataCH4;
      3'd5:    rdata_sel = rdataCH5;
      default: rdata_sel = 8'h00;
    endcase
  end

  // Dump sequencer; the single-cycle pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      raddr     <= '0;
      resp      <= 8'h00;
      send_resp <= 1'b0;
      dump_busy <= 1'b0;
      dump_done <= 1'b0;
      dump_err  <= 1'b0;
      count     <= '0;
      ch        <= 3'd0;
    end else begin
      send_resp <= 1'b0;
      dump_done <= 1'b0;
      dump_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_req) begin
            if (capture_done && ch_ok) begin
              ch        <= dump_ch;
              raddr     <= start_addr;
              count     <= '0;
              dump_busy <= 1'b1;
              state     <= READ;
            end else begin
              dump_err <= 1'b1;
            end
          end
        end
        READ: state <= LOAD;
        LOAD: begin
          resp      <= rdata_sel;
          send_resp <= 1'b1;
          state     <= WAIT_SENT;
        end
        WAIT_SENT: begin
          if (resp_sent) begin
            if (count == LAST) begin
              state <= DONE;
            end else begin
              count <= count + 1'b1;
              raddr <= (raddr == LAST) ? '0 : raddr + 1'b1;
              state <= READ;
            end
          end
        end
        DONE: begin
          dump_done <= 1'b1;
          dump_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dump_ctrl.md
Name: dump_ctrl

Overview:
- Sequences read-out of the captured sample RAMs to the host once a capture completes.
- On request, selects one channel RAM and walks raddr through all ENTRIES locations, starting at the oldest sample so the dump wraps around the circular buffer.
- For each location, loads the sample into resp and runs the send_resp/resp_sent handshake with the UART transmitter.
- Sits between the capture logic (capture_done, final write pointer), the five channel RAMs and the host response path.

Parameters:
ENTRIES, 384, number of RAM locations per channel (12288 on DE-0)
LOG2, 9, address width; must satisfy 2^LOG2 >= ENTRIES

Ports:
clk  input  1  100MHz system clock
rst_n  input  1  active-low reset
dump_req  input  1  one-cycle pulse requesting a channel dump
dump_ch  input  3  channel to dump, 1..5
capture_done  input  1  high when a complete capture is in RAM
start_addr  input  LOG2  oldest-sample address (write pointer at capture end)
rdataCH1..rdataCH5  input  8 each  RAM read data, one port per channel
resp_sent  input  1  pulse from UART: current byte has been transmitted
raddr  output  LOG2  read address to all channel RAMs
resp  output  8  byte to host
send_resp  output  1  one-cycle pulse to start transmission of resp
dump_busy  output  1  high while a dump is in progress
dump_done  output  1  one-cycle pulse after the final byte is sent
dump_err  output  1  one-cycle pulse when a request is rejected

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All state and outputs are registered.
- Reset values: raddr=0, resp=0, send_resp=0, dump_busy=0, dump_done=0, dump_err=0, FSM=IDLE, sample count=0, latched channel=0.
- Reset mid-dump aborts immediately to the reset values. No further send_resp is issued.
- RAM timing: synchronous read with 1-cycle latency. rdataCHx is valid the cycle after raddr is driven.
- FSM states: IDLE, READ, LOAD, WAIT_SENT, DONE.
- IDLE:
  - On dump_req with capture_done=1 and dump_ch in 1..5: latch dump_ch, set raddr<=start_addr and count<=0, set dump_busy<=1, go to READ.
  - On dump_req with capture_done=0, or dump_ch in {0,6,7}: pulse dump_err for 1 cycle and stay in IDLE. No bytes are sent and raddr is unchanged.
- READ: one cycle, lets the RAM output settle for the current raddr. Go to LOAD.
- LOAD:
  - resp <= rdataCHn of the latched channel.
  - send_resp <= 1 for exactly one cycle.
  - Go to WAIT_SENT.
- WAIT_SENT: hold raddr and resp until resp_sent=1, then:
  - If count==ENTRIES-1, go to DONE.
  - Otherwise count<=count+1 and raddr<=(raddr==ENTRIES-1)?0:raddr+1, then go to READ.
- Address wrap: wraps at ENTRIES-1, not at 2^LOG2-1. raddr never reaches a value >= ENTRIES.
- DONE: pulse dump_done for 1 cycle, clear dump_busy, go to IDLE. raddr keeps its last value.
- Latency:
  - dump_req sampled at edge k: raddr=start_addr from cycle k+1; resp valid and send_resp high in cycle k+3.
  - Each subsequent byte: send_resp asserts 3 cycles after the resp_sent pulse.
- Busy handling:
  - dump_req while dump_busy=1 is ignored: no error, and the dump is unaffected.
  - dump_ch and start_addr are sampled only at request acceptance; changes during a dump have no effect.
  - resp_sent outside WAIT_SENT is ignored.
- Total transfer: exactly ENTRIES send_resp pulses per accepted request, in order start_addr, start_addr+1, …, wrapping to start_addr-1 (mod ENTRIES).
- capture_done falling during a dump does not abort it.

Test Plan:
- Basic dump: RAM CH3[i]=i[7:0]; start_addr=0, dump_ch=3, capture_done=1, resp_sent returned 5 cycles after each send_resp -> 384 bytes 0x00,0x01,…,0xFF,0x00,…,0x7F; single dump_done pulse after the 384th resp_sent; dump_busy low afterward.
- Wrap-around: start_addr=380 -> raddr sequence 380,381,382,383,0,1,…,379; first resp=CH3[380]; last resp=CH3[379]; raddr never equals 384.
- Rejection: dump_ch=0, then 6, then 7 (capture_done=1), and dump_ch=2 with capture_done=0 -> four dump_err pulses, zero send_resp, dump_busy stays 0.
- Latency/handshake: dump_req at edge k -> send_resp high only in cycle k+3; resp_sent held off 100 cycles -> raddr and resp stable, no second send_resp; next send_resp exactly 3 cycles after resp_sent.
- Busy protection: second dump_req with dump_ch=5 mid-dump of CH1; dump_ch and start_addr toggled mid-dump -> all bytes still come from CH1 in the original order; exactly 384 bytes.
- Reset mid-dump: assert rst_n=0 during WAIT_SENT at byte 100 -> all outputs go to reset values asynchronously; after release, no send_resp until a new dump_req; a new dump completes normally.
